// File: rtl/pc_gen.sv
// Program-counter generator for the IF stage: fetch PC, redirect priority,
// stall-deferred redirects and a small circular return-address stack.
module pc_gen #(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(32'h0000_0000),
    parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(32'h8000_0180),
    parameter int               INC          = 4,
    parameter int               RAS_DEPTH    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             exc_valid,
    input  logic             br_taken,
    input  logic [WIDTH-1:0] br_target,
    input  logic             jmp_valid,
    input  logic [WIDTH-1:0] jmp_target,
    input  logic             jmp_pop,
    input  logic             ras_push,
    input  logic [WIDTH-1:0] ras_push_addr,
    output logic [WIDTH-1:0] pc_o,
    output logic [WIDTH-1:0] pc_plus_inc_o,
    output logic [WIDTH-1:0] ras_top_o,
    output logic             ras_empty_o,
    output logic             redir_pending_o
);

    localparam int               PTR_W      = $clog2(RAS_DEPTH);
    localparam int               CNT_W      = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(RAS_DEPTH);
    localparam logic [WIDTH-1:0] INC_VAL    = WIDTH'(INC);

    typedef enum logic [2:0] {
        SRC_NONE,
        SRC_EXC,
        SRC_BR,
        SRC_JMP_RAS,
        SRC_JMP
    } redir_src_e;

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] pc_plus_inc;
    logic             pend_valid_q, pend_valid_d;
    logic [WIDTH-1:0] pend_target_q, pend_target_d;

    logic [WIDTH-1:0] ras_mem_q [RAS_DEPTH];
    logic [WIDTH-1:0] ras_mem_d [RAS_DEPTH];
    logic [PTR_W-1:0] ras_ptr_q, ras_ptr_d;
    logic [PTR_W-1:0] ras_ptr_inc;
    logic [CNT_W-1:0] ras_cnt_q, ras_cnt_d;
    logic             ras_empty;
    logic [WIDTH-1:0] ras_top;

    redir_src_e       cand_src;
    logic [WIDTH-1:0] cand_target;
    logic             ras_en;
    logic             do_push;
    logic             do_pop;

    // Top-of-stack views come only from registered state.
    assign ras_empty   = (ras_cnt_q == '0);
    assign ras_top     = ras_empty ? '0 : ras_mem_q[ras_ptr_q];
    assign ras_ptr_inc = ras_ptr_q + PTR_W'(1);
    assign pc_plus_inc = pc_q + INC_VAL;

    always_comb begin
        cand_src = SRC_NONE;
        if (exc_valid) begin
            cand_src = SRC_EXC;
        end else if (br_taken) begin
            cand_src = SRC_BR;
        end else if (jmp_valid) begin
            cand_src = (jmp_pop && !ras_empty) ? SRC_JMP_RAS : SRC_JMP;
        end
    end

    always_comb begin
        cand_target = '0;
        case (cand_src)
            SRC_EXC:     cand_target = EXC_VECTOR;
            SRC_BR:      cand_target = br_target;
            SRC_JMP_RAS: cand_target = ras_top;
            SRC_JMP:     cand_target = jmp_target;
            default:     cand_target = '0;
        endcase
    end

    // An exception forces RAS updates through even while the front end is stalled.
    assign ras_en  = !stall || exc_valid;
    assign do_push = ras_en && ras_push;
    assign do_pop  = ras_en && (cand_src == SRC_JMP_RAS);

    always_comb begin
        ras_mem_d = ras_mem_q;
        ras_ptr_d = ras_ptr_q;
        ras_cnt_d = ras_cnt_q;
        if (do_push && do_pop) begin
            ras_mem_d[ras_ptr_q] = ras_push_addr;
        end else if (do_push) begin
            ras_ptr_d              = ras_ptr_inc;
            ras_mem_d[ras_ptr_inc] = ras_push_addr;
            if (ras_cnt_q != FULL_COUNT) begin
                ras_cnt_d = ras_cnt_q + CNT_W'(1);
            end
        end else if (do_pop) begin
            ras_ptr_d = ras_ptr_q - PTR_W'(1);
            ras_cnt_d = ras_cnt_q - CNT_W'(1);
        end
    end

    always_comb begin
        pc_d          = pc_q;
        pend_valid_d  = pend_valid_q;
        pend_target_d = pend_target_q;
        if (exc_valid) begin
            pc_d         = EXC_VECTOR;
            pend_valid_d = 1'b0;
        end else if (!stall) begin
            pend_valid_d = 1'b0;
            if (cand_src != SRC_NONE) begin
                pc_d = cand_target;
            end else if (pend_valid_q) begin
                pc_d = pend_target_q;
            end else begin
                pc_d = pc_plus_inc;
            end
        end else if (cand_src != SRC_NONE) begin
            // Last redirect seen during a stall wins.
            pend_valid_d  = 1'b1;
            pend_target_d = cand_target;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q          <= RESET_VECTOR;
            pend_valid_q  <= 1'b0;
            pend_target_q <= '0;
            ras_ptr_q     <= '0;
            ras_cnt_q     <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras_mem_q[i] <= '0;
            end
        end else begin
            pc_q          <= pc_d;
            pend_valid_q  <= pend_valid_d;
            pend_target_q <= pend_target_d;
            ras_ptr_q     <= ras_ptr_d;
            ras_cnt_q     <= ras_cnt_d;
            ras_mem_q     <= ras_mem_d;
        end
    end

    assign pc_o            = pc_q;
    assign pc_plus_inc_o   = pc_plus_inc;
    assign ras_top_o       = ras_top;
    assign ras_empty_o     = ras_empty;
    assign redir_pending_o = pend_valid_q;

endmodule

// File: tb/tb_pc_gen.sv
// Directed self-checking bench for pc_gen: sequencing, stalled redirects,
// exception priority, RAS push/pop/overwrite, and a 16-bit wrap instance.
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall, exc_valid, br_taken, jmp_valid, jmp_pop, ras_push;
    logic [31:0] br_target, jmp_target, ras_push_addr;
    logic [31:0] pc_o, pc_plus_inc_o, ras_top_o;
    logic        ras_empty_o, redir_pending_o;

    logic        zero_bit = 1'b0;
    logic [15:0] zero16   = 16'h0;
    logic [15:0] pc16, pc_plus_inc16, ras_top16;
    logic        ras_empty16, redir_pending16;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pc_gen dut (
        .clk(clk), .reset(reset), .stall(stall), .exc_valid(exc_valid),
        .br_taken(br_taken), .br_target(br_target), .jmp_valid(jmp_valid),
        .jmp_target(jmp_target), .jmp_pop(jmp_pop), .ras_push(ras_push),
        .ras_push_addr(ras_push_addr), .pc_o(pc_o), .pc_plus_inc_o(pc_plus_inc_o),
        .ras_top_o(ras_top_o), .ras_empty_o(ras_empty_o),
        .redir_pending_o(redir_pending_o)
    );

    // Narrow instance starting near the top of its address space.
    pc_gen #(
        .WIDTH(16), .RESET_VECTOR(16'hFFF8), .EXC_VECTOR(16'h0180)
    ) dut16 (
        .clk(clk), .reset(reset), .stall(zero_bit), .exc_valid(zero_bit),
        .br_taken(zero_bit), .br_target(zero16), .jmp_valid(zero_bit),
        .jmp_target(zero16), .jmp_pop(zero_bit), .ras_push(zero_bit),
        .ras_push_addr(zero16), .pc_o(pc16), .pc_plus_inc_o(pc_plus_inc16),
        .ras_top_o(ras_top16), .ras_empty_o(ras_empty16),
        .redir_pending_o(redir_pending16)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic e, input logic b, input logic [31:0] bt,
                                 input logic j, input logic [31:0] jt, input logic p,
                                 input logic pu, input logic [31:0] pa);
        stall = s; exc_valid = e; br_taken = b; br_target = bt;
        jmp_valid = j; jmp_target = jt; jmp_pop = p;
        ras_push = pu; ras_push_addr = pa;
    endtask

    task automatic idle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        tick();
        tick();
        checkOutput("rst_pc", pc_o, 32'h0);
        checkOutput("rst_pc_inc", pc_plus_inc_o, 32'h4);
        checkOutput("rst_empty", {31'b0, ras_empty_o}, 32'h1);
        checkOutput("rst_top", ras_top_o, 32'h0);
        checkOutput("rst_pend", {31'b0, redir_pending_o}, 32'h0);
        checkOutput("rst_pc16", {16'b0, pc16}, 32'hFFF8);
        reset = 1'b0;

        tick();
        checkOutput("seq_4", pc_o, 32'h4);
        checkOutput("pc16_fffc", {16'b0, pc16}, 32'hFFFC);
        checkOutput("pc16_inc_wrap", {16'b0, pc_plus_inc16}, 32'h0);
        tick();
        checkOutput("seq_8", pc_o, 32'h8);
        checkOutput("pc16_wrap", {16'b0, pc16}, 32'h0);
        checkOutput("pc16_empty", {31'b0, ras_empty16}, 32'h1);
        checkOutput("pc16_top", {16'b0, ras_top16}, 32'h0);
        checkOutput("pc16_pend", {31'b0, redir_pending16}, 32'h0);
        tick();
        checkOutput("seq_c", pc_o, 32'hC);

        // Asynchronous reset between edges.
        #3 reset = 1'b1;
        #1 checkOutput("async_rst", pc_o, 32'h0);
        reset = 1'b0;
        repeat (4) tick();
        checkOutput("seq_10", pc_o, 32'h10);

        // Branch arriving during a 3-cycle stall.
        applyStimulus(1, 0, 1, 32'h100, 0, 0, 0, 0, 0);
        tick();
        checkOutput("stall_hold1", pc_o, 32'h10);
        checkOutput("stall_pend1", {31'b0, redir_pending_o}, 32'h1);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        checkOutput("stall_hold2", pc_o, 32'h10);
        tick();
        checkOutput("stall_hold3", pc_o, 32'h10);
        checkOutput("stall_pend3", {31'b0, redir_pending_o}, 32'h1);
        idle();
        tick();
        checkOutput("pend_apply", pc_o, 32'h100);
        checkOutput("pend_clear", {31'b0, redir_pending_o}, 32'h0);
        tick();
        checkOutput("after_pend", pc_o, 32'h104);

        // Exception beats a branch and ignores stall.
        applyStimulus(1, 1, 1, 32'h200, 0, 0, 0, 0, 0);
        tick();
        checkOutput("exc_pc", pc_o, 32'h8000_0180);
        checkOutput("exc_pend", {31'b0, redir_pending_o}, 32'h0);
        idle();
        tick();
        checkOutput("exc_next", pc_o, 32'h8000_0184);

        // Last redirect during a stall wins.
        applyStimulus(1, 0, 1, 32'h400, 0, 0, 0, 0, 0);
        tick();
        applyStimulus(1, 0, 0, 0, 1, 32'h500, 0, 0, 0);
        tick();
        idle();
        tick();
        checkOutput("last_wins", pc_o, 32'h500);

        // A fresh candidate overrides a pending redirect.
        applyStimulus(1, 0, 1, 32'h600, 0, 0, 0, 0, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 1, 32'h700, 0, 0, 0);
        tick();
        checkOutput("override_pend", pc_o, 32'h700);
        idle();
        tick();
        checkOutput("override_next", pc_o, 32'h704);

        // Branch has priority over jump.
        applyStimulus(0, 0, 1, 32'h40, 1, 32'h50, 0, 0, 0);
        tick();
        checkOutput("br_over_jmp", pc_o, 32'h40);

        // Push and pop sequence.
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 32'hA0);
        tick();
        checkOutput("push_a0_top", ras_top_o, 32'hA0);
        checkOutput("push_a0_empty", {31'b0, ras_empty_o}, 32'h0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 32'hB0);
        tick();
        checkOutput("push_b0_top", ras_top_o, 32'hB0);
        applyStimulus(0, 0, 0, 0, 1, 32'h999, 1, 0, 0);
        tick();
        checkOutput("pop_b0", pc_o, 32'hB0);
        checkOutput("pop_b0_top", ras_top_o, 32'hA0);
        tick();
        checkOutput("pop_a0", pc_o, 32'hA0);
        checkOutput("pop_a0_empty", {31'b0, ras_empty_o}, 32'h1);
        checkOutput("pop_a0_top", ras_top_o, 32'h0);
        applyStimulus(0, 0, 0, 0, 1, 32'h300, 1, 0, 0);
        tick();
        checkOutput("pop_empty", pc_o, 32'h300);

        // Overflow: five pushes into four entries.
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 32'(i));
            tick();
        end
        for (int i = 5; i >= 1; i--) begin
            applyStimulus(0, 0, 0, 0, 1, 32'h900, 1, 0, 0);
            tick();
            checkOutput($sformatf("ovf_pop%0d", i), pc_o, (i == 1) ? 32'h900 : 32'(i));
        end

        // Simultaneous push and pop replaces the top.
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 32'hA0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 32'hB0);
        tick();
        applyStimulus(0, 0, 0, 0, 1, 32'h999, 1, 1, 32'hC0);
        tick();
        checkOutput("pushpop_pc", pc_o, 32'hB0);
        checkOutput("pushpop_top", ras_top_o, 32'hC0);
        applyStimulus(0, 0, 0, 0, 1, 32'h999, 1, 0, 0);
        tick();
        checkOutput("pushpop_pop1", pc_o, 32'hC0);
        checkOutput("pushpop_top2", ras_top_o, 32'hA0);
        tick();
        checkOutput("pushpop_pop2", pc_o, 32'hA0);
        checkOutput("pushpop_empty", {31'b0, ras_empty_o}, 32'h1);

        // Push during a stall is ignored.
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 32'hEE);
        tick();
        checkOutput("stall_push", {31'b0, ras_empty_o}, 32'h1);

        // Return latched during a stall uses the top at latch time.
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 32'hD0);
        tick();
        applyStimulus(1, 0, 0, 0, 1, 32'h999, 1, 0, 0);
        tick();
        checkOutput("ras_latch_pend", {31'b0, redir_pending_o}, 32'h1);
        checkOutput("ras_latch_top", ras_top_o, 32'hD0);
        idle();
        tick();
        checkOutput("ras_latch_pc", pc_o, 32'hD0);

        // Reset in the middle of a stall with a pending redirect.
        applyStimulus(1, 0, 1, 32'h123, 0, 0, 0, 0, 0);
        tick();
        checkOutput("pre_rst_pend", {31'b0, redir_pending_o}, 32'h1);
        #2 reset = 1'b1;
        #1 checkOutput("midstall_rst_pend", {31'b0, redir_pending_o}, 32'h0);
        checkOutput("midstall_rst_pc", pc_o, 32'h0);
        checkOutput("midstall_rst_empty", {31'b0, ras_empty_o}, 32'h1);
        idle();
        reset = 1'b0;
        tick();
        checkOutput("post_rst_seq", pc_o, 32'h4);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
